// File: rtl/ir_src_arbiter.sv
// ir_src_arbiter: deglitches polarity-normalised IR inputs and forwards one round-robin-granted source.
// Optional macro IR_ARB_STUCK_EN: a source marking continuously for STUCK_MS is released and locked out.
module ir_src_arbiter #(
    parameter int N_IN       = 4,
    parameter int CLK_KHZ    = 25000,
    parameter int GLITCH_CYC = 8,
    parameter int HOLD_MS    = 20,
    parameter int STUCK_MS   = 100
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N_IN-1:0] ir_in,
    input  logic [N_IN-1:0] idle_lvl,
    input  logic [N_IN-1:0] ch_en,
    input  logic            out_idle_lvl,
    output logic            ir_out,
    output logic [N_IN-1:0] grant,
    output logic            busy
);
    localparam int PW = (CLK_KHZ > 1) ? $clog2(CLK_KHZ) : 1;
    localparam int GW = $clog2(N_IN);

    if (N_IN < 2 || N_IN > 8 || CLK_KHZ < 1 || GLITCH_CYC < 1 || GLITCH_CYC > 255 ||
        HOLD_MS < 1 || HOLD_MS > 255 || STUCK_MS < 1 || STUCK_MS > 255) begin : g_param_check
        $error("ir_src_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} state_t;

    logic [N_IN-1:0] sync1, sync2, filt, act, req;
    logic [7:0]      gcnt [N_IN];
    logic [PW-1:0]   pre;
    logic            tick;
    state_t          state, state_n;
    logic [GW-1:0]   g, g_n, rr_ptr, rr_n, pick, idx;
    logic [7:0]      quiet, quiet_n;
    logic [N_IN-1:0] grant_n;
    logic            busy_n, ir_out_n, rel;

    assign act  = sync2 ^ idle_lvl;
    assign tick = pre == PW'(CLK_KHZ - 1);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1 <= '0;
            sync2 <= '0;
            filt  <= '0;
            pre   <= '0;
            for (int i = 0; i < N_IN; i++) gcnt[i] <= '0;
        end else begin
            sync1 <= ir_in;
            sync2 <= sync1;
            pre   <= tick ? '0 : pre + PW'(1);
            for (int i = 0; i < N_IN; i++) begin
                if (act[i] == filt[i]) begin
                    gcnt[i] <= '0;
                end else if (gcnt[i] == 8'(GLITCH_CYC - 1)) begin
                    filt[i] <= act[i];
                    gcnt[i] <= '0;
                end else begin
                    gcnt[i] <= gcnt[i] + 8'd1;
                end
            end
        end
    end

`ifdef IR_ARB_STUCK_EN
    logic [7:0]      stuck, stuck_n;
    logic [N_IN-1:0] lock, lock_n;
    assign req = filt & ch_en & ~lock;
    assign rel = !ch_en[g] || quiet == 8'(HOLD_MS) || stuck == 8'(STUCK_MS);
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stuck <= '0;
            lock  <= '0;
        end else begin
            stuck <= stuck_n;
            lock  <= lock_n;
        end
    end
`else
    assign req = filt & ch_en;
    assign rel = !ch_en[g] || quiet == 8'(HOLD_MS);
`endif

    // descending scan so the candidate closest to rr_ptr wins
    always_comb begin
        pick = rr_ptr;
        idx  = rr_ptr;
        for (int k = N_IN - 1; k >= 0; k--) begin
            idx = GW'((int'(rr_ptr) + k) % N_IN);
            if (req[idx]) pick = idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= IDLE;
            g      <= '0;
            rr_ptr <= '0;
            quiet  <= '0;
            grant  <= '0;
            busy   <= 1'b0;
            ir_out <= out_idle_lvl;
        end else begin
            state  <= state_n;
            g      <= g_n;
            rr_ptr <= rr_n;
            quiet  <= quiet_n;
            grant  <= grant_n;
            busy   <= busy_n;
            ir_out <= ir_out_n;
        end
    end

    always_comb begin
        state_n  = state;
        g_n      = g;
        rr_n     = rr_ptr;
        grant_n  = grant;
        busy_n   = busy;
        ir_out_n = out_idle_lvl;
        quiet_n  = filt[g] ? 8'd0 : (tick && quiet != 8'hFF) ? quiet + 8'd1 : quiet;
`ifdef IR_ARB_STUCK_EN
        stuck_n  = !filt[g] ? 8'd0 : (tick && stuck != 8'hFF) ? stuck + 8'd1 : stuck;
        lock_n   = lock & filt;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    state_n = ACTIVE;
                    g_n     = pick;
                    grant_n = {{(N_IN-1){1'b0}}, 1'b1} << pick;
                    busy_n  = 1'b1;
                    quiet_n = 8'd0;
`ifdef IR_ARB_STUCK_EN
                    stuck_n = 8'd0;
`endif
                end
            end
            ACTIVE: begin
                ir_out_n = out_idle_lvl ^ filt[g];
                if (rel) begin
                    state_n  = RELEASE;
                    grant_n  = '0;
                    busy_n   = 1'b0;
                    ir_out_n = out_idle_lvl;
                    rr_n     = (g == GW'(N_IN - 1)) ? '0 : g + GW'(1);
`ifdef IR_ARB_STUCK_EN
                    if (stuck == 8'(STUCK_MS)) lock_n[g] = 1'b1;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ir_src_arbiter.sv
// tb_ir_src_arbiter: directed stimulus; expected output changes are queued and a monitor checks each change.
module tb_ir_src_arbiter;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] ir_in = 4'b1111;
    logic [3:0] idle_lvl = 4'b0000;
    logic [3:0] ch_en = 4'b1111;
    logic       out_idle_lvl = 1'b1;
    logic       ir_out, busy;
    logic [3:0] grant;
    int         cyc = 0;
    int         r0 = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    typedef struct {
        logic [3:0] g;
        logic       b;
        logic       o;
        int         at;
        string      name;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    logic [5:0] cur;
    logic [5:0] prev = 'x;

    ir_src_arbiter #(
        .N_IN(4), .CLK_KHZ(25), .GLITCH_CYC(8), .HOLD_MS(3)
`ifdef IR_ARB_STUCK_EN
        , .STUCK_MS(5)
`endif
    ) dut (
        .clk(clk), .rstn(rstn), .ir_in(ir_in), .idle_lvl(idle_lvl), .ch_en(ch_en),
        .out_idle_lvl(out_idle_lvl), .ir_out(ir_out), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // n-th ms tick edge strictly after edge c; prescaler restarts on the first edge out of reset
    function automatic int tick_after(input int c, input int n);
        int k = 0;
        for (int t = c + 1; t < c + 10000; t++) begin
            if ((t - r0) % 25 == 0) begin
                k++;
                if (k == n) return t;
            end
        end
        return 0;
    endfunction

    task automatic expect_ev(input logic [3:0] g, input logic b, input logic o, input int at, input string name);
        exp_t x;
        x.g = g;
        x.b = b;
        x.o = o;
        x.at = at;
        x.name = name;
        exp_q.push_back(x);
    endtask

    task automatic idle_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial forever begin
        @(negedge clk);
        cur = {grant, busy, ir_out};
        if (cur !== prev) begin
            prev = cur;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_change at cycle %0d: grant=%b busy=%b ir_out=%b, required no change",
                         cyc, grant, busy, ir_out);
            end else begin
                e = exp_q.pop_front();
                if (cur !== {e.g, e.b, e.o} || (e.at >= 0 && e.at != cyc)) begin
                    n_err++;
                    $display("FAIL %s: got grant=%b busy=%b ir_out=%b at cycle %0d, required grant=%b busy=%b ir_out=%b at cycle %0d",
                             e.name, grant, busy, ir_out, cyc, e.g, e.b, e.o, e.at);
                end
            end
        end
    end

    initial begin
        int c, t;
        expect_ev(4'b0000, 1'b0, 1'b1, -1, "reset_state");
        idle_cyc(4);
        rstn = 1'b1;
        r0 = cyc;
        c = cyc;
        expect_ev(4'b0001, 1'b1, 1'b1, c + 11, "reset_exit_grant");
        expect_ev(4'b0001, 1'b1, 1'b0, c + 12, "reset_exit_mark");
        idle_cyc(30);
        ir_in = 4'b0000;
        c = cyc;
        expect_ev(4'b0001, 1'b1, 1'b1, c + 11, "first_space");
        t = tick_after(c + 10, 3) + 1;
        expect_ev(4'b0000, 1'b0, 1'b1, t, "first_release");
        wait_until(t + 5);
        // simultaneous requests on 1 and 3 with rr_ptr at 1
        ir_in = 4'b1010;
        c = cyc;
        expect_ev(4'b0010, 1'b1, 1'b1, c + 11, "rr_grant1");
        expect_ev(4'b0010, 1'b1, 1'b0, c + 12, "rr_mark1");
        idle_cyc(20);
        ir_in = 4'b1000;
        expect_ev(4'b0010, 1'b1, 1'b1, c + 31, "rr_space1");
        t = tick_after(c + 30, 3) + 1;
        expect_ev(4'b0000, 1'b0, 1'b1, t, "rr_release");
        expect_ev(4'b1000, 1'b1, 1'b1, t + 2, "rr_grant3");
        expect_ev(4'b1000, 1'b1, 1'b0, t + 3, "rr_mark3");
        wait_until(t + 6);
        ch_en = 4'b0111;
        c = cyc;
        expect_ev(4'b0000, 1'b0, 1'b1, c + 1, "disable_release");
        idle_cyc(5);
        ir_in = 4'b0000;
        idle_cyc(20);
        ch_en = 4'b1111;
        idle_cyc(5);
        // two marks 40 cycles apart stay within one grant
        ir_in = 4'b0001;
        c = cyc;
        expect_ev(4'b0001, 1'b1, 1'b1, c + 11, "hold_grant");
        expect_ev(4'b0001, 1'b1, 1'b0, c + 12, "hold_mark1");
        expect_ev(4'b0001, 1'b1, 1'b1, c + 23, "hold_space1");
        expect_ev(4'b0001, 1'b1, 1'b0, c + 63, "hold_mark2");
        expect_ev(4'b0001, 1'b1, 1'b1, c + 75, "hold_space2");
        t = tick_after(c + 74, 3) + 1;
        expect_ev(4'b0000, 1'b0, 1'b1, t, "hold_release");
        idle_cyc(12);
        ir_in = 4'b0000;
        idle_cyc(40);
        ir_in = 4'b0001;
        idle_cyc(12);
        ir_in = 4'b0000;
        wait_until(t + 5);
        ir_in = 4'b0100;
        idle_cyc(7);
        ir_in = 4'b0000;
        idle_cyc(30);
        ir_in = 4'b0100;
        c = cyc;
        expect_ev(4'b0100, 1'b1, 1'b1, c + 11, "glitch9_grant");
        expect_ev(4'b0100, 1'b1, 1'b0, c + 12, "glitch9_mark");
        expect_ev(4'b0100, 1'b1, 1'b1, c + 20, "glitch9_space");
        t = tick_after(c + 19, 3) + 1;
        expect_ev(4'b0000, 1'b0, 1'b1, t, "glitch9_release");
        idle_cyc(9);
        ir_in = 4'b0000;
        wait_until(t + 5);
        // input 0 idles high; output idles low
        ir_in = 4'b0001;
        idle_lvl = 4'b0001;
        out_idle_lvl = 1'b0;
        c = cyc;
        expect_ev(4'b0000, 1'b0, 1'b0, c + 1, "out_idle_low");
        idle_cyc(20);
        ir_in = 4'b0000;
        c = cyc;
        expect_ev(4'b0001, 1'b1, 1'b0, c + 11, "pol_grant");
        expect_ev(4'b0001, 1'b1, 1'b1, c + 12, "pol_mark");
        expect_ev(4'b0001, 1'b1, 1'b0, c + 31, "pol_space");
        t = tick_after(c + 30, 3) + 1;
        expect_ev(4'b0000, 1'b0, 1'b0, t, "pol_release");
        idle_cyc(20);
        ir_in = 4'b0001;
        wait_until(t + 5);
        ir_in = 4'b0000;
        idle_lvl = 4'b0000;
        out_idle_lvl = 1'b1;
        c = cyc;
        expect_ev(4'b0000, 1'b0, 1'b1, c + 1, "out_idle_high");
        idle_cyc(20);
`ifdef IR_ARB_STUCK_EN
        ir_in = 4'b0001;
        c = cyc;
        expect_ev(4'b0001, 1'b1, 1'b1, c + 11, "stuck_grant");
        expect_ev(4'b0001, 1'b1, 1'b0, c + 12, "stuck_mark");
        t = tick_after(c + 11, 5) + 1;
        expect_ev(4'b0000, 1'b0, 1'b1, t, "stuck_release");
        expect_ev(4'b0010, 1'b1, 1'b1, t + 2, "stuck_other_grant");
        expect_ev(4'b0010, 1'b1, 1'b0, t + 3, "stuck_other_mark");
        idle_cyc(20);
        ir_in = 4'b0011;
        wait_until(t + 6);
        ir_in = 4'b0001;
        c = cyc;
        expect_ev(4'b0010, 1'b1, 1'b1, c + 11, "stuck_other_space");
        t = tick_after(c + 10, 3) + 1;
        expect_ev(4'b0000, 1'b0, 1'b1, t, "stuck_other_release");
        wait_until(t + 40);
        ir_in = 4'b0000;
        idle_cyc(10);
        ir_in = 4'b0001;
        c = cyc;
        expect_ev(4'b0001, 1'b1, 1'b1, c + 11, "unlock_grant");
        expect_ev(4'b0001, 1'b1, 1'b0, c + 12, "unlock_mark");
        wait_until(c + 20);
`endif
        idle_cyc(10);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_events: %0d expected changes never seen, first is %s, required 0",
                     exp_q.size(), exp_q[0].name);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
